// File: rtl/pri_dec.sv
// Registered 2-to-4 priority decoder: buffers 2-bit codes in a FIFO and replays
// each one as a one-hot pulse lasting HOLD cycles, followed by a one-cycle zero gap.
module pri_dec #(
   parameter int DEPTH = 4,
   parameter int HOLD  = 2
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       req_valid,
   input  logic [1:0]                 req,
   output logic                       req_ready,
   output logic                       out1,
   output logic                       out2,
   output logic                       out3,
   output logic                       out4,
   output logic                       out_valid,
   output logic [$clog2(DEPTH):0]     count,
   output logic                       drop,
   output logic [1:0]                 state
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;
   localparam int HW = (HOLD > 1) ? $clog2(HOLD) : 1;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      DRIVE = 2'd1,
      GAP   = 2'd2
   } state_t;

   state_t          st;
   logic [1:0]      mem [DEPTH];
   logic [AW-1:0]   wptr;
   logic [AW-1:0]   rptr;
   logic [HW-1:0]   hold_cnt;
   logic [3:0]      onehot;
   logic            push;
   logic            pop;

   function automatic logic [3:0] decode(input logic [1:0] code);
      decode = 4'b0001 << code;
   endfunction

   // Handshake: a code is taken on any posedge where req_valid && req_ready.
   // req_ready depends only on the registered count, never on a same-cycle pop.
   assign req_ready = (count < CW'(DEPTH));
   assign push      = req_valid && req_ready;
   assign pop       = ((st == IDLE) || (st == GAP)) && (count != '0);

   assign {out1, out2, out3, out4} = onehot;
   assign out_valid = |onehot;
   assign state     = st;

   // Storage is not reset; stale entries are unreachable once pointers clear.
   always_ff @(posedge clk) begin
      if (push) begin
         mem[wptr] <= req;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wptr  <= '0;
         rptr  <= '0;
         count <= '0;
         drop  <= 1'b0;
      end else begin
         if (push) begin
            wptr <= wptr + 1'b1;
         end
         if (pop) begin
            rptr <= rptr + 1'b1;
         end
         case ({push, pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
         drop <= req_valid && !req_ready;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         st       <= IDLE;
         onehot   <= 4'b0000;
         hold_cnt <= '0;
      end else begin
         case (st)
            IDLE, GAP: begin
               // Leaving GAP reloads on the same edge so throughput is HOLD+1.
               if (pop) begin
                  onehot   <= decode(mem[rptr]);
                  hold_cnt <= HW'(HOLD - 1);
                  st       <= DRIVE;
               end else begin
                  onehot <= 4'b0000;
                  st     <= IDLE;
               end
            end
            DRIVE: begin
               if (hold_cnt == '0) begin
                  onehot <= 4'b0000;
                  st     <= GAP;
               end else begin
                  hold_cnt <= hold_cnt - 1'b1;
               end
            end
            default: begin
               onehot <= 4'b0000;
               st     <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_pri_dec.sv
// Directed bench for pri_dec: a vector table for the single-code, back-to-back and
// full/drop cases, then hand sequences for pointer wrap, mid-pulse reset and latency.
module tb_pri_dec;

   localparam int DEPTH = 4;
   localparam int HOLD  = 2;
   localparam int CW    = $clog2(DEPTH) + 1;

   logic          clk;
   logic          rst;
   logic          req_valid;
   logic [1:0]    req;
   logic          req_ready;
   logic          out1, out2, out3, out4;
   logic          out_valid;
   logic [CW-1:0] count;
   logic          drop;
   logic [1:0]    state;

   int n_checks = 0;
   int n_fail   = 0;

   logic [1:0] exp_q[$];

   typedef struct {
      logic          valid;
      logic [1:0]    code;
      logic [3:0]    exp_out;
      logic [1:0]    exp_state;
      logic [CW-1:0] exp_count;
      logic          exp_ready;
      logic          exp_drop;
   } vec_t;

   vec_t vq[$];

   pri_dec #(.DEPTH(DEPTH), .HOLD(HOLD)) dut (
      .clk       (clk),
      .rst       (rst),
      .req_valid (req_valid),
      .req       (req),
      .req_ready (req_ready),
      .out1      (out1),
      .out2      (out2),
      .out3      (out3),
      .out4      (out4),
      .out_valid (out_valid),
      .count     (count),
      .drop      (drop),
      .state     (state)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   task automatic props();
      logic [3:0] o;
      o = {out1, out2, out3, out4};
      n_checks++;
      if (!$onehot0(o) || (out_valid !== (|o))) begin
         n_fail++;
         $display("FAIL props: outs %b out_valid %b", o, out_valid);
      end
   endtask

   // Drive at negedge, clock one posedge, sample at the following negedge.
   task automatic cyc(input logic v, input logic [1:0] code);
      req_valid = v;
      req       = code;
      @(posedge clk);
      @(negedge clk);
      req_valid = 1'b0;
      props();
   endtask

   function automatic vec_t mk(input logic v, input logic [1:0] c, input logic [3:0] o,
                               input logic [1:0] s, input int n, input logic r, input logic d);
      vec_t t;
      t.valid     = v;
      t.code      = c;
      t.exp_out   = o;
      t.exp_state = s;
      t.exp_count = CW'(n);
      t.exp_ready = r;
      t.exp_drop  = d;
      return t;
   endfunction

   function automatic logic [1:0] code_of(input logic [3:0] o);
      case (o)
         4'b0001: code_of = 2'd0;
         4'b0010: code_of = 2'd1;
         4'b0100: code_of = 2'd2;
         default: code_of = 2'd3;
      endcase
   endfunction

   initial begin
      logic [1:0] codes [10];
      logic       found;
      string      tag;

      rst       = 1'b1;
      req_valid = 1'b0;
      req       = 2'd0;

      // single code 0
      vq.push_back(mk(1, 0, 4'b0000, 0, 1, 1, 0));
      vq.push_back(mk(0, 0, 4'b0001, 1, 0, 1, 0));
      vq.push_back(mk(0, 0, 4'b0001, 1, 0, 1, 0));
      vq.push_back(mk(0, 0, 4'b0000, 2, 0, 1, 0));
      vq.push_back(mk(0, 0, 4'b0000, 0, 0, 1, 0));
      // back-to-back 2, 1, 3
      vq.push_back(mk(1, 2, 4'b0000, 0, 1, 1, 0));
      vq.push_back(mk(1, 1, 4'b0100, 1, 1, 1, 0));
      vq.push_back(mk(1, 3, 4'b0100, 1, 2, 1, 0));
      vq.push_back(mk(0, 0, 4'b0000, 2, 2, 1, 0));
      vq.push_back(mk(0, 0, 4'b0010, 1, 1, 1, 0));
      vq.push_back(mk(0, 0, 4'b0010, 1, 1, 1, 0));
      vq.push_back(mk(0, 0, 4'b0000, 2, 1, 1, 0));
      vq.push_back(mk(0, 0, 4'b1000, 1, 0, 1, 0));
      vq.push_back(mk(0, 0, 4'b1000, 1, 0, 1, 0));
      vq.push_back(mk(0, 0, 4'b0000, 2, 0, 1, 0));
      vq.push_back(mk(0, 0, 4'b0000, 0, 0, 1, 0));
      // fill to DEPTH during pulses, one refused push
      vq.push_back(mk(1, 3, 4'b0000, 0, 1, 1, 0));
      vq.push_back(mk(1, 0, 4'b1000, 1, 1, 1, 0));
      vq.push_back(mk(1, 1, 4'b1000, 1, 2, 1, 0));
      vq.push_back(mk(1, 2, 4'b0000, 2, 3, 1, 0));
      vq.push_back(mk(1, 3, 4'b0001, 1, 3, 1, 0));
      vq.push_back(mk(1, 2, 4'b0001, 1, 4, 0, 0));
      vq.push_back(mk(1, 1, 4'b0000, 2, 4, 0, 1));
      vq.push_back(mk(0, 0, 4'b0010, 1, 3, 1, 0));
      vq.push_back(mk(0, 0, 4'b0010, 1, 3, 1, 0));
      vq.push_back(mk(0, 0, 4'b0000, 2, 3, 1, 0));
      vq.push_back(mk(0, 0, 4'b0100, 1, 2, 1, 0));
      vq.push_back(mk(0, 0, 4'b0100, 1, 2, 1, 0));
      vq.push_back(mk(0, 0, 4'b0000, 2, 2, 1, 0));
      vq.push_back(mk(0, 0, 4'b1000, 1, 1, 1, 0));
      vq.push_back(mk(0, 0, 4'b1000, 1, 1, 1, 0));
      vq.push_back(mk(0, 0, 4'b0000, 2, 1, 1, 0));
      vq.push_back(mk(0, 0, 4'b0100, 1, 0, 1, 0));
      vq.push_back(mk(0, 0, 4'b0100, 1, 0, 1, 0));
      vq.push_back(mk(0, 0, 4'b0000, 2, 0, 1, 0));
      vq.push_back(mk(0, 0, 4'b0000, 0, 0, 1, 0));

      // reset state
      repeat (2) @(negedge clk);
      check("rst_outs", 32'({out1, out2, out3, out4}), 32'h0);
      check("rst_count", 32'(count), 32'h0);
      rst = 1'b0;
      @(negedge clk);
      check("rel_ready", 32'(req_ready), 32'h1);
      check("rel_valid", 32'(out_valid), 32'h0);
      check("rel_drop", 32'(drop), 32'h0);
      check("rel_state", 32'(state), 32'h0);

      foreach (vq[i]) begin
         cyc(vq[i].valid, vq[i].code);
         tag = $sformatf("v%0d", i);
         check({tag, "_outs"}, 32'({out1, out2, out3, out4}), 32'(vq[i].exp_out));
         check({tag, "_ovalid"}, 32'(out_valid), 32'(|vq[i].exp_out));
         check({tag, "_state"}, 32'(state), 32'(vq[i].exp_state));
         check({tag, "_count"}, 32'(count), 32'(vq[i].exp_count));
         check({tag, "_ready"}, 32'(req_ready), 32'(vq[i].exp_ready));
         check({tag, "_drop"}, 32'(drop), 32'(vq[i].exp_drop));
      end

      // steady push+pop at count=2 across pointer wrap
      codes = '{2'd3, 2'd1, 2'd0, 2'd2, 2'd2, 2'd3, 2'd0, 2'd1, 2'd3, 2'd2};
      exp_q.push_back(2'd1);
      cyc(1, 2'd1);
      exp_q.push_back(2'd2);
      cyc(1, 2'd2);
      check("wrap_first", 32'(code_of({out1, out2, out3, out4})), 32'(exp_q.pop_front()));
      exp_q.push_back(2'd0);
      cyc(1, 2'd0);
      cyc(0, 2'd0);
      for (int k = 0; k < 10; k++) begin
         exp_q.push_back(codes[k]);
         cyc(1, codes[k]);
         check($sformatf("wrap_out%0d", k), 32'(code_of({out1, out2, out3, out4})),
               32'(exp_q.pop_front()));
         check($sformatf("wrap_cnt%0d", k), 32'(count), 32'h2);
         check($sformatf("wrap_ov%0d", k), 32'(out_valid), 32'h1);
         cyc(0, 2'd0);
         cyc(0, 2'd0);
      end
      for (int k = 0; k < 2; k++) begin
         cyc(0, 2'd0);
         check($sformatf("drain_out%0d", k), 32'(code_of({out1, out2, out3, out4})),
               32'(exp_q.pop_front()));
         cyc(0, 2'd0);
         cyc(0, 2'd0);
      end
      cyc(0, 2'd0);
      check("drain_count", 32'(count), 32'h0);
      check("drain_state", 32'(state), 32'h0);

      // asynchronous reset in the middle of a code-3 pulse
      cyc(1, 2'd3);
      cyc(1, 2'd0);
      check("pre_rst_out1", 32'(out1), 32'h1);
      check("pre_rst_count", 32'(count), 32'h1);
      #2 rst = 1'b1;
      #1;
      check("async_out1", 32'(out1), 32'h0);
      check("async_ovalid", 32'(out_valid), 32'h0);
      check("async_count", 32'(count), 32'h0);
      @(negedge clk);
      rst = 1'b0;
      cyc(1, 2'd1);
      check("post_rst_idle", 32'({out1, out2, out3, out4}), 32'h0);
      cyc(0, 2'd0);
      check("post_rst_pulse", 32'({out1, out2, out3, out4}), 32'h2);
      cyc(0, 2'd0);
      check("post_rst_hold", 32'({out1, out2, out3, out4}), 32'h2);
      cyc(0, 2'd0);
      check("post_rst_gap", 32'({out1, out2, out3, out4}), 32'h0);
      cyc(0, 2'd0);
      check("post_rst_state", 32'(state), 32'h0);

      // code 2 queued behind three others must surface within the bound
      cyc(1, 2'd0);
      cyc(1, 2'd1);
      cyc(1, 2'd3);
      cyc(1, 2'd2);
      found = 1'b0;
      for (int i = 0; i < 1 + DEPTH * (HOLD + 1) && !found; i++) begin
         cyc(0, 2'd0);
         if (out2) found = 1'b1;
      end
      check("out2_latency", 32'(found), 32'h1);
      for (int i = 0; i < 20 && !(count == '0 && state == 2'd0); i++) begin
         cyc(0, 2'd0);
      end
      check("final_count", 32'(count), 32'h0);
      check("final_state", 32'(state), 32'h0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
